conv_window_scheduler: RTL
==========================

Name: conv_window_scheduler

Overview:
- Sequences one convolution pass over an IMG_H x IMG_W feature map: generates kernel-window origin coordinates in raster order and issues them to the windowed dot-product engine over a valid/ready handshake.
- Limits in-flight windows to MAX_OUTSTANDING and tags each returned dot-product result with its linear output address.
- Optionally applies ReLU to each result.
- Sits between the layer controller (start/done) and the line-buffer/dot-product datapath.

Parameters:
- IMG_W, 8: input map width, in pixels.
- IMG_H, 8: input map height, in pixels.
- KERNEL_SIZE, 3: square kernel edge; must be <= IMG_W and <= IMG_H.
- STRIDE, 1: window step in both axes, >= 1.
- BIT_REP_OUT, 8: signed result width.
- MAX_OUTSTANDING, 4: maximum issued-but-unreturned windows, >= 1.
- Derived values:
  - OUT_W = (IMG_W-KERNEL_SIZE)/STRIDE+1
  - OUT_H = (IMG_H-KERNEL_SIZE)/STRIDE+1
  - TOTAL = OUT_W*OUT_H
  - ADDR_W = max(1, $clog2(TOTAL))

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a pass; sampled only in IDLE.
- busy  out  1  high while a pass is in progress.
- done  out  1  one-cycle pulse when the final result is delivered.
- win_valid  out  1  window coordinate valid.
- win_ready  in  1  dot-product engine accepts the window.
- win_row  out  max(1,$clog2(IMG_H))  top row of the window.
- win_col  out  max(1,$clog2(IMG_W))  left column of the window.
- dp_valid  in  1  dot-product result valid.
- dp_ready  out  1  scheduler accepts the result.
- dp_data  in  BIT_REP_OUT  signed result.
- out_valid  out  1  tagged result valid.
- out_ready  in  1  sink accepts the result.
- out_data  out  BIT_REP_OUT  signed result, possibly ReLU'd.
- out_addr  out  ADDR_W  linear output index, oy*OUT_W+ox.

Behaviour:
- Reset (async assert, sync deassert) clears all state immediately, even mid-pass:
  - state=IDLE; busy, done and win_valid = 0.
  - win_row, win_col, out_addr and the outstanding count = 0.
  - In-flight windows are abandoned; the datapath is reset alongside.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: start=1 -> ISSUE on the next edge; busy=1 from that cycle; coordinates at (0,0).
  - ISSUE -> DRAIN on the handshake of the last window (row=(OUT_H-1)*STRIDE, col=(OUT_W-1)*STRIDE).
  - DRAIN -> IDLE on the handshake of result TOTAL-1; done=1 and busy=0 in the following cycle.
- start while busy is ignored.
- win_valid = (state==ISSUE) && (outstanding < MAX_OUTSTANDING).
  - Combinational from registered state; no dependency on win_ready.
- Coordinate advance, on a win handshake only:
  - col += STRIDE.
  - When col reaches (OUT_W-1)*STRIDE: col=0, row += STRIDE.
  - Coordinates hold while win_ready=0.
- Outstanding counter:
  - +1 on win handshake, -1 on dp handshake; both in the same cycle -> unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- Result path is combinational pass-through, zero latency:
  - out_valid = dp_valid && busy && (outstanding != 0).
  - dp_ready = out_ready && busy && (outstanding != 0).
  - out_data = dp_data (ReLU applied if enabled).
  - out_addr = registered result counter; increments on the dp/out handshake.
- Results are assumed returned in issue order, so address = issue index.
- dp_valid with outstanding==0 or in IDLE: not accepted (dp_ready=0), no state change.
- The final window issue and result return may coincide in the same cycle; counters stay consistent.
- TOTAL=1: a single issue, then DRAIN.

Optional Feature:
- CONV_RELU_EN defined: out_data = (dp_data[BIT_REP_OUT-1]) ? 0 : dp_data.
- CONV_RELU_EN undefined: out_data = dp_data unmodified.
- Handshake timing is identical either way.

Test Plan:
- 5x5 map, K=3, S=1, win_ready=out_ready=1, results returned 2 cycles after issue:
  - -> 9 windows (0,0),(0,1),(0,2),(1,0)..(2,2).
  - -> out_addr 0..8 in order.
  - -> done pulses once, one cycle after addr 8 is handshaken; busy then 0.
- 5x5 map, S=2 -> windows (0,0),(0,2),(2,0),(2,2); TOTAL=4; out_addr 0..3.
- MAX_OUTSTANDING=2, dp_valid withheld:
  - -> exactly 2 window handshakes, then win_valid=0.
  - One result returned -> win_valid=1 the next cycle.
- win_ready toggled randomly:
  - -> coordinates hold across stall cycles; no coordinate skipped or repeated.
  - start pulsed mid-pass -> ignored.
- rst_n asserted in DRAIN with 3 outstanding:
  - -> all outputs 0 immediately.
  - A fresh start then yields (0,0) and out_addr 0.
- CONV_RELU_EN defined, dp_data=-5 (8'hFB) -> out_data=0; dp_data=7 -> 7. Undefined: -5 passes through as 8'hFB.

Source files
------------

// File: rtl/conv_window_scheduler.sv
// Raster-order kernel-window issuer with bounded in-flight windows and in-order result tagging.
// Optional macro CONV_RELU_EN clamps negative results to zero; result path is zero latency.
module conv_window_scheduler #(
   parameter int IMG_W           = 8,
   parameter int IMG_H           = 8,
   parameter int KERNEL_SIZE     = 3,
   parameter int STRIDE          = 1,
   parameter int BIT_REP_OUT     = 8,
   parameter int MAX_OUTSTANDING = 4,
   localparam int OUT_W  = (IMG_W - KERNEL_SIZE) / STRIDE + 1,
   localparam int OUT_H  = (IMG_H - KERNEL_SIZE) / STRIDE + 1,
   localparam int TOTAL  = OUT_W * OUT_H,
   localparam int ADDR_W = (TOTAL > 1) ? $clog2(TOTAL) : 1,
   localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1,
   localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   win_valid,
   input  logic                   win_ready,
   output logic [ROW_W-1:0]       win_row,
   output logic [COL_W-1:0]       win_col,
   input  logic                   dp_valid,
   output logic                   dp_ready,
   input  logic [BIT_REP_OUT-1:0] dp_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [BIT_REP_OUT-1:0] out_data,
   output logic [ADDR_W-1:0]      out_addr
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'((OUT_H - 1) * STRIDE);
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'((OUT_W - 1) * STRIDE);
   localparam logic [ROW_W-1:0]  ROW_STEP  = ROW_W'(STRIDE);
   localparam logic [COL_W-1:0]  COL_STEP  = COL_W'(STRIDE);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_OUTSTANDING);

   logic [1:0]        state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;

   logic has_out, win_hs, dp_hs, last_win, last_res;

   assign busy      = (state_q != S_IDLE);
   assign has_out   = (cnt_q != '0);
   assign win_valid = (state_q == S_ISSUE) && (cnt_q < MAX_CNT);
   assign win_hs    = win_valid && win_ready;
   assign out_valid = dp_valid && busy && has_out;
   assign dp_ready  = out_ready && busy && has_out;
   assign dp_hs     = dp_valid && dp_ready;
   assign last_win  = (row_q == LAST_ROW) && (col_q == LAST_COL);
   assign last_res  = (addr_q == LAST_ADDR);

   assign win_row  = row_q;
   assign win_col  = col_q;
   assign out_addr = addr_q;
   assign done     = done_q;

`ifdef CONV_RELU_EN
   assign out_data = dp_data[BIT_REP_OUT-1] ? '0 : dp_data;
`else
   assign out_data = dp_data;
`endif

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE:  if (start) state_d = S_ISSUE;
         S_ISSUE: if (win_hs && last_win) state_d = S_DRAIN;
         S_DRAIN: if (dp_hs && last_res) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Coordinates rewind after the last window so the next pass starts at the origin.
      if (win_hs) begin
         if (last_win) begin
            row_d = '0;
            col_d = '0;
         end else if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + ROW_STEP;
         end else begin
            col_d = col_q + COL_STEP;
         end
      end

      if (dp_hs) addr_d = last_res ? '0 : addr_q + ADDR_W'(1);

      case ({win_hs, dp_hs})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

endmodule
